// File: rtl/lcd_hd44780_ctrl_pkg.sv
// rtl/lcd_hd44780_ctrl_pkg.sv - package lcd_pkg: word ROM, LCD command bytes, FSM state types
package lcd_pkg;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] DDRAM0   = 8'h80;

    // Index 0 is the most significant 64-bit slice; characters are left to right.
    localparam logic [0:7][63:0] WORD_ROM = {
        "WELCOME ", "RECORD  ", "UP      ", "DOWN    ",
        "LEFT    ", "RIGHT   ", "STOP    ", "----    "
    };

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHARS
    } top_state_e;

    typedef enum logic [2:0] {
        WR_PWRUP,
        WR_IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } wr_state_e;

    function automatic logic [7:0] word_char(input logic [2:0] sel, input logic [2:0] idx);
        logic [63:0] w;
        w = WORD_ROM[sel] << {idx, 3'b000};
        return w[63:56];
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = FUNC_SET;
            2'd1:    cmd = DISP_ON;
            2'd2:    cmd = CLEAR;
            default: cmd = ENTRY;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// rtl/lcd_hd44780_ctrl_if.sv - word request handshake and LCD pin bundle
interface lcd_hd44780_ctrl_if;
    logic       word_valid;
    logic [2:0] word_sel;
    logic       word_ready;
    logic       disp_done;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    modport master (
        output word_valid, word_sel,
        input  word_ready, disp_done, init_done, lcd_data, lcd_rs, lcd_rw, lcd_en
    );

    modport slave (
        input  word_valid, word_sel,
        output word_ready, disp_done, init_done, lcd_data, lcd_rs, lcd_rw, lcd_en
    );
endinterface

// File: rtl/lcd_hd44780_ctrl_byte_writer.sv
// rtl/lcd_hd44780_ctrl_byte_writer.sv - lcd_byte_writer: SETUP/PULSE/HOLD byte engine, owns the delay counter
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC = 750_000,
    parameter int E_CYC     = 25,
    parameter int CMD_CYC   = 2_000,
    parameter int CLR_CYC   = 82_000
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    input  logic       rs_i,
    output logic       done_o,
    output logic       idle_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_en_o
);
    localparam int MAX_CYC = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] PWRUP_LD = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] E_LD     = CW'(E_CYC - 1);
    localparam logic [CW-1:0] CMD_LD   = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] CLR_LD   = CW'(CLR_CYC - 1);

    wr_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          done;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= WR_PWRUP;
            cnt_q   <= PWRUP_LD;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
        end
    end

    // done is raised in the last wait cycle so the next byte's SETUP follows with no gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        done    = 1'b0;
        case (state_q)
            WR_PWRUP: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = WR_IDLE;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = E_LD;
            end
            WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                    cnt_d   = (!rs_q && data_q == CLEAR) ? CLR_LD : CMD_LD;
                end
            end
            WR_HOLD: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = WR_IDLE;
                end
            end
            default: ;
        endcase
        if (start_i && (state_q == WR_IDLE || done)) begin
            state_d = WR_SETUP;
            data_d  = byte_i;
            rs_d    = rs_i;
        end
    end

    assign done_o     = done;
    assign idle_o     = (state_q == WR_IDLE);
    assign lcd_data_o = data_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_en_o   = (state_q == WR_PULSE);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// rtl/lcd_hd44780_ctrl.sv - HD44780 init and full-word write sequencer; LCD_SKIP_REPEAT_EN skips repeated words
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int PWRUP_CYC = 750_000,
    parameter int E_CYC     = 25,
    parameter int CMD_CYC   = 2_000,
    parameter int CLR_CYC   = 82_000
) (
    input  logic               clk,
    input  logic               rstb,
    lcd_hd44780_ctrl_if.slave  bus
);
    if (CLK_FREQ <= 0) begin : g_clk_freq_check
        $error("CLK_FREQ must be positive");
    end

    top_state_e state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] sel_q, sel_d;
    logic       done_q, done_d;
    logic       init_q, init_d;

    logic       wr_start, wr_rs, wr_done, wr_idle;
    logic [7:0] wr_byte;

`ifdef LCD_SKIP_REPEAT_EN
    logic [2:0] last_q, last_d;
    logic       last_vld_q, last_vld_d;
    logic       skip_q, skip_d;
`endif

    lcd_byte_writer #(
        .PWRUP_CYC (PWRUP_CYC),
        .E_CYC     (E_CYC),
        .CMD_CYC   (CMD_CYC),
        .CLR_CYC   (CLR_CYC)
    ) u_writer (
        .clk        (clk),
        .rstb       (rstb),
        .start_i    (wr_start),
        .byte_i     (wr_byte),
        .rs_i       (wr_rs),
        .done_o     (wr_done),
        .idle_o     (wr_idle),
        .lcd_data_o (bus.lcd_data),
        .lcd_rs_o   (bus.lcd_rs),
        .lcd_en_o   (bus.lcd_en)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_PWRUP;
            idx_q      <= 4'd0;
            sel_q      <= 3'd0;
            done_q     <= 1'b0;
            init_q     <= 1'b0;
`ifdef LCD_SKIP_REPEAT_EN
            last_q     <= 3'd0;
            last_vld_q <= 1'b0;
            skip_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            init_q     <= init_d;
`ifdef LCD_SKIP_REPEAT_EN
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            skip_q     <= skip_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        done_d     = 1'b0;
        init_d     = init_q;
        wr_start   = 1'b0;
        wr_byte    = 8'h00;
        wr_rs      = 1'b0;
`ifdef LCD_SKIP_REPEAT_EN
        last_d     = last_q;
        last_vld_d = last_vld_q;
        skip_d     = 1'b0;
`endif
        case (state_q)
            ST_PWRUP: begin
                if (wr_done) begin
                    wr_start = 1'b1;
                    wr_byte  = init_cmd(2'd0);
                    idx_d    = 4'd1;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                if (wr_done) begin
                    if (idx_q == 4'd4) begin
                        state_d = ST_IDLE;
                        init_d  = 1'b1;
                    end else begin
                        wr_start = 1'b1;
                        wr_byte  = init_cmd(idx_q[1:0]);
                        idx_d    = idx_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
`ifdef LCD_SKIP_REPEAT_EN
                done_d = skip_q;
                if (bus.word_valid) begin
                    if (last_vld_q && bus.word_sel == last_q) begin
                        skip_d = 1'b1;
                    end else begin
                        sel_d   = bus.word_sel;
                        state_d = ST_ADDR;
                    end
                end
`else
                if (bus.word_valid) begin
                    sel_d   = bus.word_sel;
                    state_d = ST_ADDR;
                end
`endif
            end
            ST_ADDR: begin
                // The writer is idle only on the entry cycle; afterwards wait for the address byte to finish.
                if (wr_idle) begin
                    wr_start = 1'b1;
                    wr_byte  = DDRAM0;
                end else if (wr_done) begin
                    wr_start = 1'b1;
                    wr_byte  = word_char(sel_q, 3'd0);
                    wr_rs    = 1'b1;
                    idx_d    = 4'd1;
                    state_d  = ST_CHARS;
                end
            end
            ST_CHARS: begin
                if (wr_done) begin
                    if (idx_q == 4'd8) begin
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
`ifdef LCD_SKIP_REPEAT_EN
                        last_d     = sel_q;
                        last_vld_d = 1'b1;
`endif
                    end else begin
                        wr_start = 1'b1;
                        wr_byte  = word_char(sel_q, idx_q[2:0]);
                        wr_rs    = 1'b1;
                        idx_d    = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    assign bus.word_ready = (state_q == ST_IDLE);
    assign bus.disp_done  = done_q;
    assign bus.init_done  = init_q;
    assign bus.lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb/tb_lcd_hd44780_ctrl.sv - self-checking bench for lcd_hd44780_ctrl (vector table, random requests, reference model)
module tb_lcd_hd44780_ctrl;
    localparam int PW      = 10;
    localparam int EC      = 2;
    localparam int CC      = 4;
    localparam int CL      = 8;
    localparam int BYTE_L  = 1 + EC + CC;
    localparam int WORD_L  = 1 + 9 * BYTE_L;
    localparam int INIT_L  = PW + 3 * BYTE_L + (1 + EC + CL);
`ifdef LCD_SKIP_REPEAT_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstb = 1'b0;

    lcd_hd44780_ctrl_if bus ();

    lcd_hd44780_ctrl #(
        .CLK_FREQ  (50_000_000),
        .PWRUP_CYC (PW),
        .E_CYC     (EC),
        .CMD_CYC   (CC),
        .CLR_CYC   (CL)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [63:0] text;
        int          busy_at;
    } vec_t;

    logic [8:0]  cap_q[$];
    logic [8:0]  exp_q[$];
    int          hi_q[$];
    int          gap_q[$];
    int          hi_cnt, lo_cnt, pulses, hold_err;
    bit          en_prev;
    logic [63:0] wtext[8];
    bit          last_vld;
    logic [2:0]  last_sel;
    int          passed, total;

    // Bus monitor: one record per enable pulse, plus high-time and low-gap lengths.
    always @(negedge clk) begin
        if (!rstb) begin
            en_prev = 1'b0;
        end else begin
            if (bus.lcd_en) begin
                if (!en_prev) begin
                    cap_q.push_back({bus.lcd_rs, bus.lcd_data});
                    if (pulses > 0) gap_q.push_back(lo_cnt);
                    pulses++;
                    hi_cnt = 0;
                end else if (cap_q.size() > 0 && {bus.lcd_rs, bus.lcd_data} != cap_q[$]) begin
                    hold_err++;
                end
                hi_cnt++;
            end else begin
                if (en_prev) begin
                    hi_q.push_back(hi_cnt);
                    lo_cnt = 0;
                end
                lo_cnt++;
            end
            en_prev = bus.lcd_en;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cmp_bytes(input string name);
        chk({name, " byte count"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s byte %0d", name, i), 64'(cap_q[i]), 64'(exp_q[i]));
    endtask

    task automatic model_req(input logic [2:0] sel, input logic [63:0] text, output int lat, output bit skipped);
        exp_q.delete();
        if (SKIP && last_vld && sel == last_sel) begin
            lat     = 1;
            skipped = 1'b1;
        end else begin
            lat     = WORD_L;
            skipped = 1'b0;
            exp_q.push_back(9'h080);
            for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, text[63-8*i -: 8]});
            last_vld = 1'b1;
            last_sel = sel;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.word_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.word_ready) chk("word_ready wait", 64'(bus.word_ready), 64'd1);
    endtask

    task automatic init_check(input string name);
        int k = 0;
        logic prev_init = 1'b0;
        do begin
            prev_init = bus.init_done;
            @(posedge clk); #1;
            k++;
        end while (!bus.word_ready && k < INIT_L + 50);
        chk({name, " ready edge"}, 64'(k), 64'(INIT_L));
        chk({name, " init_done"}, 64'(bus.init_done), 64'd1);
        chk({name, " init_done prior"}, 64'(prev_init), 64'd0);
        exp_q = '{9'h038, 9'h00C, 9'h001, 9'h006};
        cmp_bytes(name);
        foreach (hi_q[i]) chk($sformatf("%s en high %0d", name, i), 64'(hi_q[i]), 64'(EC));
        chk({name, " gap count"}, 64'(gap_q.size()), 64'd3);
        if (gap_q.size() == 3) begin
            chk({name, " gap after 0x38"}, 64'(gap_q[0]), 64'(CC + 1));
            chk({name, " gap after 0x01"}, 64'(gap_q[2]), 64'(CL + 1));
        end
    endtask

    task automatic run_req(input string name, input logic [2:0] sel, input logic [63:0] text, input int busy_at);
        int lat, k;
        bit sk;
        wait_ready();
        bus.word_sel   = sel;
        bus.word_valid = 1'b1;
        @(posedge clk); #1;
        bus.word_valid = 1'b0;
        cap_q.delete();
        model_req(sel, text, lat, sk);
        chk({name, " ready after accept"}, 64'(bus.word_ready), 64'(sk));
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
            if (k == busy_at) begin
                bus.word_sel   = sel + 3'd1;
                bus.word_valid = 1'b1;
                @(posedge clk); #1;
                k++;
                bus.word_valid = 1'b0;
            end
        end while (!bus.disp_done && k < lat + 20);
        chk({name, " done latency"}, 64'(k), 64'(lat));
        chk({name, " ready at done"}, 64'(bus.word_ready), 64'd1);
        cmp_bytes(name);
        @(posedge clk); #1;
        chk({name, " done one cycle"}, 64'(bus.disp_done), 64'd0);
    endtask

    vec_t tbl[7];

    initial begin
        int k, lat;
        bit sk;
        logic [2:0] rsel, prev_sel;

        wtext = '{"WELCOME ", "RECORD  ", "UP      ", "DOWN    ",
                  "LEFT    ", "RIGHT   ", "STOP    ", "----    "};
        tbl[0] = '{3'd5, "RIGHT   ", -1};
        tbl[1] = '{3'd5, "RIGHT   ", -1};
        tbl[2] = '{3'd6, "STOP    ", -1};
        tbl[3] = '{3'd6, "STOP    ", -1};
        tbl[4] = '{3'd0, "WELCOME ", 12};
        tbl[5] = '{3'd3, "DOWN    ", -1};
        tbl[6] = '{3'd4, "LEFT    ", 30};
        passed = 0; total = 0; pulses = 0; hold_err = 0; hi_cnt = 0; lo_cnt = 0;
        last_vld = 1'b0; last_sel = 3'd0;
        bus.word_valid = 1'b0;
        bus.word_sel   = 3'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset word_ready", 64'(bus.word_ready), 64'd0);
        chk("reset disp_done",  64'(bus.disp_done),  64'd0);
        chk("reset init_done",  64'(bus.init_done),  64'd0);
        chk("reset lcd_data",   64'(bus.lcd_data),   64'd0);
        chk("reset lcd_rs",     64'(bus.lcd_rs),     64'd0);
        chk("reset lcd_rw",     64'(bus.lcd_rw),     64'd0);
        chk("reset lcd_en",     64'(bus.lcd_en),     64'd0);
        rstb = 1'b1;
        init_check("init");

        foreach (tbl[i]) run_req($sformatf("vec%0d", i), tbl[i].sel, tbl[i].text, tbl[i].busy_at);

        // Back-to-back: valid held, word_sel changed mid-write, second accept on the disp_done cycle.
        wait_ready();
        bus.word_sel   = 3'd2;
        bus.word_valid = 1'b1;
        @(posedge clk); #1;
        cap_q.delete();
        model_req(3'd2, wtext[2], lat, sk);
        bus.word_sel = 3'd7;
        chk("b2b first busy", 64'(bus.word_ready), 64'd0);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!bus.disp_done && k < lat + 20);
        chk("b2b first latency", 64'(k), 64'(lat));
        chk("b2b ready at done", 64'(bus.word_ready), 64'd1);
        cmp_bytes("b2b UP");
        @(posedge clk); #1;
        bus.word_valid = 1'b0;
        chk("b2b second accepted", 64'(bus.word_ready), 64'd0);
        cap_q.delete();
        model_req(3'd7, wtext[7], lat, sk);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!bus.disp_done && k < lat + 20);
        chk("b2b second latency", 64'(k), 64'(lat));
        cmp_bytes("b2b dashes");

        // Reset in the enable pulse of character 3.
        wait_ready();
        bus.word_sel   = 3'd1;
        bus.word_valid = 1'b1;
        @(posedge clk); #1;
        bus.word_valid = 1'b0;
        cap_q.delete();
        k = 0;
        while (cap_q.size() < 5 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("char3 pulse en", 64'(bus.lcd_en), 64'd1);
        if (cap_q.size() == 5) chk("char3 byte", 64'(cap_q[4]), 64'h14F);
        rstb = 1'b0;
        #1;
        chk("async en drop", 64'(bus.lcd_en), 64'd0);
        chk("reset ready drop", 64'(bus.word_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        cap_q.delete(); hi_q.delete(); gap_q.delete();
        pulses = 0;
        last_vld = 1'b0;
        rstb = 1'b1;
        init_check("reinit");
        run_req("after reset", 3'd1, wtext[1], -1);

        prev_sel = 3'd1;
        for (int i = 0; i < 12; i++) begin
            rsel = (i % 4 == 3) ? prev_sel : 3'($urandom_range(0, 7));
            run_req($sformatf("rand%0d", i), rsel, wtext[rsel], (i % 3 == 0) ? 20 : -1);
            prev_sel = rsel;
        end

        chk("data stable in pulse", 64'(hold_err), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_ctrl.md
# lcd_hd44780_ctrl

Sequencer for the character-LCD datapath. Runs the HD44780-style power-up and initialisation sequence, then accepts word-display requests over a valid/ready handshake and writes the selected 8-character word to LCD line 1, byte by byte, with controller-safe enable pulsing and execution waits. It sits between the voice-classification result and the LCD pins, replacing per-character slow scanning with full-word updates.

## Interface
- `CLK_FREQ`, 50_000_000, clock frequency in Hz; documentation only, all delays are set in cycles.
- `PWRUP_CYC`, 750_000, wait after reset release before the first command (15 ms at 50 MHz).
- `E_CYC`, 25, `lcd_en` high time in cycles (500 ns).
- `CMD_CYC`, 2_000, post-pulse wait for normal commands and data (40 µs).
- `CLR_CYC`, 82_000, post-pulse wait for the clear command 0x01 (1.64 ms).

Ports:
- `clk` in 1: single clock.
- `rstb` in 1: asynchronous, active-low reset.
- `word_valid` in 1: display request.
- `word_sel` in 3: word index: 0 WELCOME, 1 RECORD, 2 UP, 3 DOWN, 4 LEFT, 5 RIGHT, 6 STOP, 7 "----" (silence). Each word is space-padded to 8 characters.
- `word_ready` out 1: high only in IDLE.
- `disp_done` out 1: one-cycle pulse when a word write completes.
- `init_done` out 1: high once initialisation has finished; stays high until the next reset.
- `lcd_data` out 8: LCD data bus.
- `lcd_rs` out 1: 0 = command, 1 = data.
- `lcd_rw` out 1: tied to 0 (write only).
- `lcd_en` out 1: LCD enable strobe.

## Operation
- Reset values: all outputs are 0, including `word_ready`, `disp_done`, `init_done`, `lcd_data`, `lcd_rs`, `lcd_rw` and `lcd_en`.
- The last-word register is reset to invalid.
- Top FSM states:
  - PWRUP: counts `PWRUP_CYC` cycles, then goes to INIT.
  - INIT: issues commands 0x38, 0x0C, 0x01, 0x06 in that order, then goes to IDLE and sets `init_done`.
  - IDLE: waits for a request.
  - ADDR: issues command 0x80 (DDRAM address 0).
  - CHARS: issues data bytes 0..7 of the latched word, then returns to IDLE.
- Byte transaction (identical for commands and data):
  - SETUP, 1 cycle: `lcd_rs` and `lcd_data` driven, `lcd_en` = 0.
  - PULSE, `E_CYC` cycles: `lcd_en` = 1.
  - HOLD: `lcd_en` = 0 for `CLR_CYC` cycles if the byte is command 0x01, otherwise `CMD_CYC` cycles.
  - `lcd_data` and `lcd_rs` hold their values through PULSE and HOLD.
  - After HOLD they stay at the last values until the next SETUP.
- Handshake:
  - A request is accepted on a cycle with `word_valid` && `word_ready`; `word_sel` is latched on that edge.
  - `word_ready` drops the cycle after acceptance.
  - `word_valid` while not ready is ignored and must be held by the requester.
- A new request can be accepted in the same cycle `disp_done` pulses.
- A `word_sel` change during a write has no effect on that write.
- Character index 0..7 counts up; the FSM exits after index 7 with no wrap.
- A reset mid-transaction forces `lcd_en` low immediately (asynchronously) and restarts from PWRUP.

## Timing
- Byte length: 1 + `E_CYC` + wait cycles.
- Initialisation: `word_ready` and `init_done` rise exactly PWRUP_CYC + 3·(1+E_CYC+CMD_CYC) + (1+E_CYC+CLR_CYC) rising edges after `rstb` deasserts. With defaults this is 838,104 edges.
- Word write, accepted at edge N:
  - SETUP of 0x80 at edge N+1.
  - `disp_done` and `word_ready` high at edge N+1 + 9·(1+E_CYC+CMD_CYC). With defaults this is N+18,235.
- Delay counter: one shared down-counter of width $clog2(max(PWRUP_CYC, CLR_CYC)+1), loaded at each phase entry.

## Configuration
- `LCD_SKIP_REPEAT_EN` defined:
  - A request whose `word_sel` equals the last fully displayed word is accepted.
  - It produces no bus activity.
  - `disp_done` pulses the next cycle and `word_ready` stays high.
  - The last-word register updates only at a `disp_done` that follows a real write.
- Not defined: every accepted request rewrites the display in full. The last-word register is not implemented.

## Structure
- Package `lcd_pkg` holds:
  - The 8×8 word ROM constant.
  - Command byte constants (FUNC_SET 0x38, DISP_ON 0x0C, CLEAR 0x01, ENTRY 0x06, DDRAM0 0x80).
  - The top-FSM state enum.
- Sub-module `lcd_byte_writer` implements the SETUP/PULSE/HOLD engine with start/done signals and owns the delay counter. The top FSM only sequences bytes.

## Test plan
All scenarios use PWRUP_CYC=10, E_CYC=2, CMD_CYC=4, CLR_CYC=8 unless stated.
- Reset release:
  - All outputs read 0 during reset.
  - Bus shows 0x38, 0x0C, 0x01, 0x06 with `lcd_rs`=0.
  - `word_ready` and `init_done` rise at edge 42.
  - The `lcd_en` high time is 2 cycles, and the post-pulse gap after 0x01 is 8 cycles.
- Request `word_sel`=5 at edge N:
  - Bus shows 0x80 (`lcd_rs`=0), then "RIGHT   " (`lcd_rs`=1).
  - `disp_done` pulses at N+64 and `word_ready` returns high at N+64.
- Back-to-back requests:
  - Hold `word_valid` with `word_sel`=2, then 7.
  - The second request is accepted on the `disp_done` cycle, and "UP" followed by "----" is written.
- `word_valid` pulsed for 1 cycle while busy: ignored, with no extra bus transaction.
- Reset pulse during the PULSE phase of character 3: `lcd_en` drops at once, and the full init sequence repeats with `word_ready` high 42 edges after release.
- With `LCD_SKIP_REPEAT_EN` defined, request 6 twice:
  - The second request produces zero `lcd_en` pulses and `disp_done` one cycle after acceptance.
  - Without the macro, the second request produces 9 `lcd_en` pulses.
